// File: rtl/rf_write_scheduler_pkg.sv
// rtl/rf_write_scheduler_pkg.sv - shared constants and FSM type for the register-file write scheduler
package rf_write_scheduler_pkg;

  localparam int XLEN_DEF         = 32;
  localparam int NUM_REGS_DEF     = 32;
  localparam int REG_IDX_W        = 5;
  localparam int STARVE_LIMIT_DEF = 4;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    WS_NORMAL,
    WS_FORCE
  } ws_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - busy bits for destinations owed by the long-latency unit
module rf_scoreboard
  import rf_write_scheduler_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int IW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [IW-1:0] set_rd,
  input  logic          clr_en,
  input  logic [IW-1:0] clr_rd,
  input  logic [IW-1:0] rd_a,
  input  logic [IW-1:0] rd_b,
  input  logic [IW-1:0] rd_c,
  output logic          hit_a,
  output logic          hit_b,
  output logic          hit_c
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  // Set is applied after clear so a same-cycle reissue of the completing rd stays busy.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_rd] = 1'b0;
    if (set_en) busy_nxt[set_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign hit_a = busy[rd_a] && (rd_a != '0);
  assign hit_b = busy[rd_b] && (rd_b != '0);
  assign hit_c = busy[rd_c] && (rd_c != '0);

endmodule

// File: rtl/rf_write_scheduler.sv
// rtl/rf_write_scheduler.sv - shares the single register-file write port between pipeline WB and the LU
module rf_write_scheduler
  import rf_write_scheduler_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int NUM_REGS     = NUM_REGS_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int IW           = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_wb_valid,
  input  logic [IW-1:0]   pipe_wb_rd,
  input  logic [XLEN-1:0] pipe_wb_data,
  output logic            pipe_stall,
  input  logic            lu_req_valid,
  input  logic [IW-1:0]   lu_req_rd,
  input  logic [XLEN-1:0] lu_req_data,
  output logic            lu_req_ready,
  input  logic            issue_valid,
  input  logic [IW-1:0]   issue_rd,
  input  logic [IW-1:0]   id_rs1,
  input  logic [IW-1:0]   id_rs2,
  input  logic [IW-1:0]   id_rd,
  output logic            hazard_stall,
  output logic [IW-1:0]   WB_rd,
  output logic [XLEN-1:0] WB_data
);

  localparam int CW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_LIMIT - 1);

  ws_state_e     state;
  logic [CW-1:0] starve_cnt;

  logic pipe_act, lu_act, lu_zero;
  logic grant_pipe, grant_lu;
  logic contended, lu_xfer;
  logic hit_rs1, hit_rs2, hit_rd;

  // Requests to x0 never occupy the port.
  assign pipe_act = pipe_wb_valid && (pipe_wb_rd != ZERO_REG);
  assign lu_act   = lu_req_valid && (lu_req_rd != ZERO_REG);
  assign lu_zero  = lu_req_valid && (lu_req_rd == ZERO_REG);

  always_comb begin
    grant_pipe   = 1'b0;
    grant_lu     = 1'b0;
    lu_req_ready = 1'b0;
    pipe_stall   = 1'b0;
    if (!rst) begin
      case (state)
        WS_NORMAL: begin
          if (lu_zero) lu_req_ready = 1'b1;
          if (pipe_act) begin
            grant_pipe = 1'b1;
          end else if (lu_act) begin
            grant_lu     = 1'b1;
            lu_req_ready = 1'b1;
          end
        end
        WS_FORCE: begin
          // Stall regardless of pipe_wb_valid so a WB arriving this cycle is held, not lost.
          if (lu_req_valid) begin
            lu_req_ready = 1'b1;
            pipe_stall   = 1'b1;
            grant_lu     = lu_act;
          end else begin
            grant_pipe = pipe_act;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    WB_rd   = ZERO_REG;
    WB_data = '0;
    if (grant_lu) begin
      WB_rd   = lu_req_rd;
      WB_data = lu_req_data;
    end else if (grant_pipe) begin
      WB_rd   = pipe_wb_rd;
      WB_data = pipe_wb_data;
    end
  end

  assign contended = (state == WS_NORMAL) && pipe_act && lu_act;
  assign lu_xfer   = lu_req_valid && lu_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WS_NORMAL;
      starve_cnt <= '0;
    end else begin
      case (state)
        WS_NORMAL: begin
          if (contended) begin
            if (starve_cnt == CNT_LAST) begin
              state      <= WS_FORCE;
              starve_cnt <= '0;
            end else begin
              starve_cnt <= starve_cnt + CW'(1);
            end
          end else if (lu_xfer || !lu_req_valid) begin
            starve_cnt <= '0;
          end
        end
        WS_FORCE: begin
          state      <= WS_NORMAL;
          starve_cnt <= '0;
        end
        default: begin
          state      <= WS_NORMAL;
          starve_cnt <= '0;
        end
      endcase
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .IW       (IW)
  ) u_scoreboard (
    .clk    (clk),
    .rst    (rst),
    .set_en (issue_valid && (issue_rd != ZERO_REG)),
    .set_rd (issue_rd),
    .clr_en (lu_xfer && lu_act),
    .clr_rd (lu_req_rd),
    .rd_a   (id_rs1),
    .rd_b   (id_rs2),
    .rd_c   (id_rd),
    .hit_a  (hit_rs1),
    .hit_b  (hit_rs2),
    .hit_c  (hit_rd)
  );

  // No bypass: a destination completing this cycle still stalls ID.
  assign hazard_stall = !rst && (hit_rs1 || hit_rs2 || hit_rd);

  // WAW stalling in ID must keep the pipeline from ever writing an LU-owned register.
  always_ff @(posedge clk) begin
    if (!rst && pipe_act) begin
      assert (!u_scoreboard.busy[pipe_wb_rd]);
    end
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// tb/tb_rf_write_scheduler.sv - directed self-checking bench for rf_write_scheduler
module tb_rf_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_rd;
  logic [31:0] pipe_wb_data;
  logic        pipe_stall;
  logic        lu_req_valid;
  logic [4:0]  lu_req_rd;
  logic [31:0] lu_req_data;
  logic        lu_req_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        hazard_stall;
  logic [4:0]  WB_rd;
  logic [31:0] WB_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_write_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .pipe_wb_valid (pipe_wb_valid),
    .pipe_wb_rd    (pipe_wb_rd),
    .pipe_wb_data  (pipe_wb_data),
    .pipe_stall    (pipe_stall),
    .lu_req_valid  (lu_req_valid),
    .lu_req_rd     (lu_req_rd),
    .lu_req_data   (lu_req_data),
    .lu_req_ready  (lu_req_ready),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rd         (id_rd),
    .hazard_stall  (hazard_stall),
    .WB_rd         (WB_rd),
    .WB_data       (WB_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    pipe_wb_valid = 1'b0; pipe_wb_rd = '0; pipe_wb_data = '0;
    lu_req_valid  = 1'b0; lu_req_rd  = '0; lu_req_data  = '0;
    issue_valid   = 1'b0; issue_rd   = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk_out(input string tag, input logic [4:0] rd, input logic [31:0] data,
                         input logic rdy, input logic stl);
    chk({tag, "_wb_rd"}, 32'(WB_rd), 32'(rd));
    chk({tag, "_wb_data"}, WB_data, data);
    chk({tag, "_ready"}, 32'(lu_req_ready), 32'(rdy));
    chk({tag, "_pipe_stall"}, 32'(pipe_stall), 32'(stl));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    cyc();
    cyc();
    id_rs1 = 5'd1;
    settle();
    chk_out("rst", 5'd0, 32'h0, 1'b0, 1'b0);
    chk("rst_hazard", 32'(hazard_stall), 32'd0);
    cyc();
    rst = 1'b0;

    // 1: pipeline-only write
    idle();
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd5; pipe_wb_data = 32'h11;
    settle();
    chk_out("t1", 5'd5, 32'h11, 1'b0, 1'b0);
    cyc();

    // 2: issue, RAW hazard, completion without bypass
    idle();
    issue_valid = 1'b1; issue_rd = 5'd7;
    settle();
    chk("t2_idle_wb", 32'(WB_rd), 32'd0);
    cyc();
    idle();
    id_rs1 = 5'd7;
    settle();
    chk("t2_hazard_set", 32'(hazard_stall), 32'd1);
    cyc();
    lu_req_valid = 1'b1; lu_req_rd = 5'd7; lu_req_data = 32'hAB;
    settle();
    chk_out("t2_lu", 5'd7, 32'hAB, 1'b1, 1'b0);
    chk("t2_hazard_completing", 32'(hazard_stall), 32'd1);
    cyc();
    lu_req_valid = 1'b0;
    settle();
    chk("t2_hazard_cleared", 32'(hazard_stall), 32'd0);
    cyc();

    // 3: starvation forces an LU grant after STARVE_LIMIT=4 refusals
    idle();
    lu_req_valid = 1'b1; lu_req_rd = 5'd9; lu_req_data = 32'h99;
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd10;
    for (int i = 0; i < 4; i++) begin
      pipe_wb_data = 32'h100 + 32'(i);
      settle();
      chk_out($sformatf("t3_pipe%0d", i), 5'd10, 32'h100 + 32'(i), 1'b0, 1'b0);
      cyc();
    end
    pipe_wb_data = 32'h104;
    settle();
    chk_out("t3_force", 5'd9, 32'h99, 1'b1, 1'b1);
    cyc();
    lu_req_valid = 1'b0;
    settle();
    chk_out("t3_held_pipe", 5'd10, 32'h104, 1'b0, 1'b0);
    cyc();
    lu_req_valid = 1'b1; pipe_wb_data = 32'h105;
    settle();
    chk_out("t3_cnt_restart", 5'd10, 32'h105, 1'b0, 1'b0);
    cyc();

    // 4: LU to x0 accepted alongside a pipeline write
    idle();
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd3; pipe_wb_data = 32'h33;
    lu_req_valid = 1'b1; lu_req_rd = 5'd0; lu_req_data = 32'hDEAD;
    settle();
    chk_out("t4", 5'd3, 32'h33, 1'b1, 1'b0);
    cyc();
    idle();
    id_rs1 = 5'd9; id_rs2 = 5'd3; id_rd = 5'd0;
    settle();
    chk("t4_busy_unchanged", 32'(hazard_stall), 32'd0);
    cyc();

    // 5: same-cycle issue and completion of rd=4 leaves it busy
    idle();
    issue_valid = 1'b1; issue_rd = 5'd4;
    lu_req_valid = 1'b1; lu_req_rd = 5'd4; lu_req_data = 32'h44;
    settle();
    chk_out("t5_xfer", 5'd4, 32'h44, 1'b1, 1'b0);
    cyc();
    idle();
    id_rs2 = 5'd4;
    settle();
    chk("t5_set_wins", 32'(hazard_stall), 32'd1);
    lu_req_valid = 1'b1; lu_req_rd = 5'd4; lu_req_data = 32'h45;
    cyc();
    lu_req_valid = 1'b0;
    settle();
    chk("t5_cleared", 32'(hazard_stall), 32'd0);
    cyc();

    // 6: reset during a forced grant with x2 and x6 busy
    idle();
    issue_valid = 1'b1; issue_rd = 5'd2;
    cyc();
    issue_rd = 5'd6;
    cyc();
    idle();
    id_rs1 = 5'd2; id_rd = 5'd6;
    lu_req_valid = 1'b1; lu_req_rd = 5'd13; lu_req_data = 32'h13;
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd11; pipe_wb_data = 32'h11;
    settle();
    chk("t6_hazard_busy", 32'(hazard_stall), 32'd1);
    for (int i = 0; i < 4; i++) cyc();
    settle();
    chk("t6_in_force", 32'(pipe_stall), 32'd1);
    rst = 1'b1;
    settle();
    chk_out("t6_rst", 5'd0, 32'h0, 1'b0, 1'b0);
    chk("t6_rst_hazard", 32'(hazard_stall), 32'd0);
    cyc();
    rst = 1'b0;
    settle();
    chk("t6_busy_cleared", 32'(hazard_stall), 32'd0);
    chk_out("t6_normal", 5'd11, 32'h11, 1'b0, 1'b0);
    cyc();
    idle();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
